// File: rtl/display_feeder.sv
// Step-button debouncer, display source mux and scan clock divider for the CPU board.
// Optional DISP_SNAPSHOT_EN freezes DispData between step pulses and Sel changes.
module display_feeder #(
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Btn,
  input  logic [1:0]  Sel,
  input  logic [31:0] PC,
  input  logic [31:0] NextPC,
  input  logic [4:0]  RsAddr,
  input  logic [4:0]  RtAddr,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  input  logic [31:0] AluResult,
  input  logic [31:0] DB,
  output logic        StepPulse,
  output logic        ScanClk,
  output logic [15:0] DispData
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic             b1_q, b1_d;
  logic             b2_q, b2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             step_pulse_q, step_pulse_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             scan_clk_q, scan_clk_d;
  logic [15:0]      disp_q, disp_d;
  logic [15:0]      disp_sel;
`ifdef DISP_SNAPSHOT_EN
  logic [1:0]       sel_q, sel_d;
`endif

  // Only the low byte of each datapath word reaches the display.
  logic unused_bits;
  assign unused_bits = ^{PC[31:8], NextPC[31:8], RsData[31:8], RtData[31:8],
                         AluResult[31:8], DB[31:8]};

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q      <= IDLE;
      b1_q         <= 1'b0;
      b2_q         <= 1'b0;
      cnt_q        <= '0;
      step_pulse_q <= 1'b0;
      div_q        <= '0;
      scan_clk_q   <= 1'b0;
      disp_q       <= 16'h0000;
`ifdef DISP_SNAPSHOT_EN
      sel_q        <= 2'b00;
`endif
    end else begin
      state_q      <= state_d;
      b1_q         <= b1_d;
      b2_q         <= b2_d;
      cnt_q        <= cnt_d;
      step_pulse_q <= step_pulse_d;
      div_q        <= div_d;
      scan_clk_q   <= scan_clk_d;
      disp_q       <= disp_d;
`ifdef DISP_SNAPSHOT_EN
      sel_q        <= sel_d;
`endif
    end
  end

  always_comb begin
    b1_d         = Btn;
    b2_d         = b1_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    step_pulse_d = 1'b0;
    cnt_inc      = cnt_q + CNT_W'(1);
    div_d        = div_q + DIV_W'(1);
    scan_clk_d   = scan_clk_q;
    disp_sel     = 16'h0000;
    disp_d       = disp_q;
`ifdef DISP_SNAPSHOT_EN
    sel_d        = Sel;
`endif

    // Debounce: a level is accepted only after DEB_CYCLES consecutive equal samples.
    case (state_q)
      IDLE: begin
        if (b2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!b2_q) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            state_d      = PRESSED;
            step_pulse_d = 1'b1;
          end
        end
      end
      PRESSED: begin
        if (!b2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (b2_q) begin
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Free-running divider; ScanClk flips each time the counter wraps.
    if (div_q == DIV_LAST) begin
      div_d      = '0;
      scan_clk_d = ~scan_clk_q;
    end

    case (Sel)
      2'b00:   disp_sel = {PC[7:0], NextPC[7:0]};
      2'b01:   disp_sel = {3'b000, RsAddr, RsData[7:0]};
      2'b10:   disp_sel = {3'b000, RtAddr, RtData[7:0]};
      default: disp_sel = {AluResult[7:0], DB[7:0]};
    endcase

`ifdef DISP_SNAPSHOT_EN
    if (step_pulse_q || (Sel != sel_q)) begin
      disp_d = disp_sel;
    end
`else
    disp_d = disp_sel;
`endif
  end

  assign StepPulse = step_pulse_q;
  assign ScanClk   = scan_clk_q;
  assign DispData  = disp_q;

endmodule

// File: tb/tb_display_feeder.sv
// Scoreboard bench for display_feeder: a per-edge reference model feeds a queue, a monitor compares.
module tb_display_feeder;

  localparam int unsigned DEB  = 4;
  localparam int unsigned SDIV = 3;

  logic        CLK;
  logic        Reset;
  logic        Btn;
  logic [1:0]  Sel;
  logic [31:0] PC, NextPC, RsData, RtData, AluResult, DB;
  logic [4:0]  RsAddr, RtAddr;
  logic        StepPulse, ScanClk;
  logic [15:0] DispData;

  typedef struct packed {
    logic        p;
    logic        s;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_no = 0;
  int   pulse_seen = 0;
  int   model_pulses = 0;
  int   last_pulse_edge = -1;
  int   rise_q[$];

  display_feeder #(.DEB_CYCLES(DEB), .SCAN_DIV(SDIV)) dut (
    .CLK(CLK), .Reset(Reset), .Btn(Btn), .Sel(Sel),
    .PC(PC), .NextPC(NextPC), .RsAddr(RsAddr), .RtAddr(RtAddr),
    .RsData(RsData), .RtData(RtData), .AluResult(AluResult), .DB(DB),
    .StepPulse(StepPulse), .ScanClk(ScanClk), .DispData(DispData)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, edge %0d", edge_no);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pack_disp(input logic [1:0] s);
    case (s)
      2'd0:    return {PC[7:0], NextPC[7:0]};
      2'd1:    return {3'b000, RsAddr, RsData[7:0]};
      2'd2:    return {3'b000, RtAddr, RtData[7:0]};
      default: return {AluResult[7:0], DB[7:0]};
    endcase
  endfunction

  // Reference model: accepted level flips after DEB consecutive differing synced samples.
  initial begin : model
    logic        s1, s2, fin, lvl, m_pulse;
    logic [15:0] m_disp, nd;
    logic [1:0]  m_sel;
    int          run, k;
    s1 = 0; s2 = 0; lvl = 0; m_pulse = 0; m_disp = 0; m_sel = 0; run = 0; k = 0;
    forever begin
      @(posedge CLK);
      edge_no++;
      if (!Reset) begin
        s1 = 0; s2 = 0; lvl = 0; run = 0; m_pulse = 0; k = 0; m_disp = 16'h0000; m_sel = 2'd0;
      end else begin
        fin = s2;
        s2  = s1;
        s1  = Btn;
        nd  = pack_disp(Sel);
`ifdef DISP_SNAPSHOT_EN
        if (m_pulse || (Sel != m_sel)) m_disp = nd;
        m_sel = Sel;
`else
        m_disp = nd;
`endif
        m_pulse = 1'b0;
        if (fin != lvl) begin
          run++;
          if (run == DEB) begin
            lvl = fin;
            run = 0;
            m_pulse = fin;
          end
        end else begin
          run = 0;
        end
        k++;
      end
      if (m_pulse) model_pulses++;
      exp_q.push_back('{p: m_pulse, s: (((k / SDIV) % 2) == 1), d: m_disp});
    end
  end

  // Monitor: compare every registered output once per edge.
  initial begin : monitor
    exp_t e;
    logic prev_scan;
    prev_scan = 1'b0;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("step_pulse", 16'(StepPulse), 16'(e.p));
        chk("scan_clk", 16'(ScanClk), 16'(e.s));
        chk("disp_data", DispData, e.d);
        if (StepPulse === 1'b1) begin
          pulse_seen++;
          last_pulse_edge = edge_no;
        end
        if (ScanClk === 1'b1 && prev_scan === 1'b0) rise_q.push_back(edge_no);
        prev_scan = ScanClk;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic btn_for(input logic v, input int n);
    Btn = v;
    cyc(n);
  endtask

  initial begin : stim
    int r, e0, p0, hold;
    Reset = 1'b0; Btn = 1'b1; Sel = 2'd0;
    PC = 0; NextPC = 0; RsAddr = 0; RtAddr = 0; RsData = 0; RtData = 0; AluResult = 0; DB = 0;

    // Reset with button held, then release: pulse at +6, ScanClk rises at +3/+9/+15.
    cyc(3);
    Reset = 1'b1;
    r = edge_no;
    rise_q.delete();
    while (edge_no < r + 17) cyc(1);
    chk_int("reset_release_pulses", pulse_seen, 1);
    chk_int("reset_release_pulse_edge", last_pulse_edge - r, 6);
    chk_int("scan_rise_count", rise_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < rise_q.size()) chk_int("scan_rise_edge", rise_q[i] - r, 3 + 6 * i);
    end

    // Short glitch, then a real press.
    btn_for(1'b0, 12);
    p0 = pulse_seen;
    btn_for(1'b1, 3);
    btn_for(1'b0, 2);
    e0 = edge_no;
    btn_for(1'b1, 10);
    btn_for(1'b0, 12);
    chk_int("glitch_press_pulses", pulse_seen - p0, 1);
    chk_int("glitch_press_pulse_edge", last_pulse_edge - e0, 6);

    // Long hold with release bounce.
    p0 = pulse_seen;
    btn_for(1'b1, 50);
    btn_for(1'b0, 2);
    btn_for(1'b1, 2);
    btn_for(1'b0, 2);
    btn_for(1'b1, 2);
    btn_for(1'b0, 20);
    chk_int("bounce_release_pulses", pulse_seen - p0, 1);

    // Mux mapping, one edge of latency.
    Sel = 2'd1; RsAddr = 5'd3; RsData = 32'h0000_00FF;
    cyc(1);
    chk("mux_rs", DispData, 16'h03FF);
    Sel = 2'd3; AluResult = 32'hFFFF_FF2A; DB = 32'h0000_002A;
    cyc(1);
    chk("mux_alu_db", DispData, 16'h2A2A);
    Sel = 2'd2; RtAddr = 5'd31; RtData = 32'h1234_56AB;
    cyc(1);
    chk("mux_rt", DispData, 16'h1FAB);
    Sel = 2'd0; PC = 32'h0000_0014; NextPC = 32'h0000_0018;
    cyc(1);
    chk("mux_pc", DispData, 16'h1418);
    cyc(3);

    // Reset mid-debounce discards the pending press.
    p0 = pulse_seen;
    btn_for(1'b1, 4);
    Reset = 1'b0;
    Btn = 1'b0;
    cyc(2);
    Reset = 1'b1;
    cyc(10);
    chk_int("mid_debounce_reset_pulses", pulse_seen - p0, 0);

    // Randomised traffic; Sel also moves on pulse cycles.
    hold = 0;
    for (int i = 0; i < 500; i++) begin
      if (hold == 0) begin
        Btn  = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 9);
      end
      hold--;
      if (StepPulse === 1'b1 || $urandom_range(0, 7) == 0) Sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        PC = $urandom; NextPC = $urandom; RsData = $urandom; RtData = $urandom;
        AluResult = $urandom; DB = $urandom;
        RsAddr = 5'($urandom_range(0, 31)); RtAddr = 5'($urandom_range(0, 31));
      end
      Reset = ($urandom_range(0, 89) != 0);
      cyc(1);
    end

    Reset = 1'b1;
    cyc(4);
    #1;
    chk_int("queue_drained", exp_q.size(), 0);
    chk_int("total_pulses", pulse_seen, model_pulses);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
